// File: rtl/dmac_rd_burst_gen.sv
// AXI read-address burst generator: splits a (pointer, remaining length) request into one
// AR burst bounded by length, MAX_BURST_LEN and the 4 KB boundary, and returns the updated pointer.
module dmac_rd_burst_gen #(
  parameter int             ADDR_WD       = 32,
  parameter int             DATA_WD       = 32,
  parameter int             MAX_BURST_LEN = 16,
  parameter int             ID_WD         = 4,
  parameter logic [ID_WD-1:0] ARID_VAL    = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_req_valid,
  input  logic [ADDR_WD-1:0] rd_req_addr,
  input  logic [1:0]         rd_req_burst,
  input  logic [ADDR_WD-1:0] rd_req_length,
  input  logic [2:0]         rd_req_size,
  output logic               rd_req_ack,
  output logic [ADDR_WD-1:0] rd_req_next_addr,
  output logic [ADDR_WD-1:0] rd_req_next_length,
  output logic               rd_req_done,
  output logic               m_axi_arvalid,
  input  logic               m_axi_arready,
  output logic [ADDR_WD-1:0] m_axi_araddr,
  output logic [7:0]         m_axi_arlen,
  output logic [2:0]         m_axi_arsize,
  output logic [1:0]         m_axi_arburst,
  output logic [ID_WD-1:0]   m_axi_arid
);

  localparam int STRB_WD  = DATA_WD / 8;
  localparam int MAX_SIZE = $clog2(STRB_WD);
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {IDLE, CALC, ADDR} state_e;

  state_e             state_q, state_d;
  logic [ADDR_WD-1:0] addr_q, length_q;
  logic [2:0]         size_q;
  logic [1:0]         burst_q;
  logic [8:0]         beats_q;

  logic [ADDR_WD-1:0] size_mask, len_beats, beats_calc, burst_bytes;
  logic [12:0]        k4_beats;

  // Beat count: ceil(length / bytes_per_beat), clipped by burst limit and the 4 KB page.
  always_comb begin
    size_mask  = ~({ADDR_WD{1'b1}} << size_q);
    len_beats  = (length_q >> size_q) + ADDR_WD'(|(length_q & size_mask));
    k4_beats   = (burst_q == BURST_FIXED) ? 13'(MAX_BURST_LEN)
                                          : (13'd4096 - {1'b0, addr_q[11:0]}) >> size_q;
    beats_calc = len_beats;
    if (beats_calc > ADDR_WD'(MAX_BURST_LEN)) beats_calc = ADDR_WD'(MAX_BURST_LEN);
    if (beats_calc > ADDR_WD'(k4_beats))      beats_calc = ADDR_WD'(k4_beats);
    burst_bytes = ADDR_WD'(beats_q) << size_q;
  end

  always_comb begin
    state_d       = state_q;
    rd_req_ack    = 1'b0;
    m_axi_arvalid = 1'b0;
    unique case (state_q)
      IDLE: if (rd_req_valid) state_d = CALC;
      CALC: begin
        if (length_q == '0) begin
          rd_req_ack = 1'b1;
          state_d    = IDLE;
        end else begin
          state_d    = ADDR;
        end
      end
      ADDR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) begin
          rd_req_ack = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Only an empty request acks from CALC, so the pointer is returned unchanged there.
  always_comb begin
    if (state_q == CALC) begin
      rd_req_next_addr   = addr_q;
      rd_req_next_length = '0;
    end else begin
      rd_req_next_addr   = (burst_q == BURST_FIXED) ? addr_q : addr_q + burst_bytes;
      rd_req_next_length = (length_q > burst_bytes) ? length_q - burst_bytes : '0;
    end
    rd_req_done = (rd_req_next_length == '0);
  end

  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = 8'(beats_q - 9'd1);
  assign m_axi_arsize  = size_q;
  assign m_axi_arburst = burst_q;
  assign m_axi_arid    = ARID_VAL;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: the request datapath has no reset; it is always reloaded before the FSM consumes it.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && rd_req_valid) begin
      addr_q   <= rd_req_addr;
      length_q <= rd_req_length;
      size_q   <= (rd_req_size > 3'(MAX_SIZE)) ? 3'(MAX_SIZE) : rd_req_size;
      burst_q  <= (rd_req_burst == BURST_FIXED) ? BURST_FIXED : BURST_INCR;
    end
    if (state_q == CALC) beats_q <= 9'(beats_calc);
  end

endmodule

// File: tb/tb_dmac_rd_burst_gen.sv
// Directed bench for dmac_rd_burst_gen (DATA_WD=32, MAX_BURST_LEN=16); values hand-computed.
module tb_dmac_rd_burst_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_req_valid;
  logic [31:0] rd_req_addr;
  logic [1:0]  rd_req_burst;
  logic [31:0] rd_req_length;
  logic [2:0]  rd_req_size;
  logic        rd_req_ack;
  logic [31:0] rd_req_next_addr;
  logic [31:0] rd_req_next_length;
  logic        rd_req_done;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic [3:0]  m_axi_arid;

  int n_cmp = 0;
  int n_err = 0;

  dmac_rd_burst_gen #(
    .ADDR_WD(32), .DATA_WD(32), .MAX_BURST_LEN(16), .ID_WD(4), .ARID_VAL(4'h0)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_burst(rd_req_burst),
    .rd_req_length(rd_req_length), .rd_req_size(rd_req_size),
    .rd_req_ack(rd_req_ack), .rd_req_next_addr(rd_req_next_addr),
    .rd_req_next_length(rd_req_next_length), .rd_req_done(rd_req_done),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arid(m_axi_arid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive a request for one cycle; returns at the negedge where the DUT is in CALC.
  task automatic send(input logic [31:0] a, input logic [31:0] l, input logic [2:0] s,
                      input logic [1:0] b);
    rd_req_valid  = 1'b1;
    rd_req_addr   = a;
    rd_req_length = l;
    rd_req_size   = s;
    rd_req_burst  = b;
    @(negedge clk);
    rd_req_valid  = 1'b0;
  endtask

  // Full burst with arready held high: CALC, ADDR (ack), back to IDLE.
  task automatic burst(input string tag, input logic [31:0] a, input logic [31:0] l,
                       input logic [2:0] s, input logic [1:0] b,
                       input logic [7:0] e_len, input logic [2:0] e_size, input logic [1:0] e_burst,
                       input logic [31:0] e_naddr, input logic [31:0] e_nlen, input logic e_done);
    m_axi_arready = 1'b1;
    send(a, l, s, b);
    check({tag, " calc arvalid"}, m_axi_arvalid, 1'b0);
    check({tag, " calc ack"},     rd_req_ack,    1'b0);
    @(negedge clk);
    check({tag, " arvalid"},   m_axi_arvalid,      1'b1);
    check({tag, " araddr"},    m_axi_araddr,       a);
    check({tag, " arlen"},     m_axi_arlen,        e_len);
    check({tag, " arsize"},    m_axi_arsize,       e_size);
    check({tag, " arburst"},   m_axi_arburst,      e_burst);
    check({tag, " arid"},      m_axi_arid,         4'h0);
    check({tag, " ack"},       rd_req_ack,         1'b1);
    check({tag, " next_addr"}, rd_req_next_addr,   e_naddr);
    check({tag, " next_len"},  rd_req_next_length, e_nlen);
    check({tag, " done"},      rd_req_done,        e_done);
    @(negedge clk);
    check({tag, " idle arvalid"}, m_axi_arvalid, 1'b0);
    check({tag, " idle ack"},     rd_req_ack,    1'b0);
  endtask

  initial begin
    rst = 1'b1; rd_req_valid = 1'b0; rd_req_addr = '0; rd_req_burst = '0;
    rd_req_length = '0; rd_req_size = '0; m_axi_arready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset arvalid", m_axi_arvalid, 1'b0);
    check("reset ack",     rd_req_ack,    1'b0);
    rst = 1'b0;

    // Request issued in the first cycle after reset; 4 KB split at 0x1000.
    burst("k4a", 32'h0FF0, 32'd64, 3'd2, 2'b01, 8'd3,  3'd2, 2'b01, 32'h1000, 32'd48, 1'b0);
    burst("k4b", 32'h1000, 32'd48, 3'd2, 2'b01, 8'd11, 3'd2, 2'b01, 32'h1030, 32'd0,  1'b1);

    // Length-limited by MAX_BURST_LEN, then a WRAP request issued as INCR.
    burst("mxa", 32'h0000, 32'd100, 3'd2, 2'b01, 8'd15, 3'd2, 2'b01, 32'h0040, 32'd36, 1'b0);
    burst("mxb", 32'h0040, 32'd36,  3'd2, 2'b10, 8'd8,  3'd2, 2'b01, 32'h0064, 32'd0,  1'b1);

    burst("fix", 32'h2000, 32'd128, 3'd2, 2'b00, 8'd15, 3'd2, 2'b00, 32'h2000, 32'd64, 1'b0);

    // Partial final beat rounds up; byte-size beats; 4 KB edge right at the last byte.
    burst("part", 32'h0100, 32'd6,  3'd2, 2'b01, 8'd1,  3'd2, 2'b01, 32'h0108, 32'd0, 1'b1);
    burst("byte", 32'h0FFF, 32'd10, 3'd0, 2'b11, 8'd0,  3'd0, 2'b01, 32'h1000, 32'd9, 1'b0);

    // Zero length: ack in CALC, no AR at all.
    send(32'h0ABC, 32'd0, 3'd2, 2'b01);
    check("zero arvalid",   m_axi_arvalid,      1'b0);
    check("zero ack",       rd_req_ack,         1'b1);
    check("zero done",      rd_req_done,        1'b1);
    check("zero next_addr", rd_req_next_addr,   32'h0ABC);
    check("zero next_len",  rd_req_next_length, 32'd0);
    @(negedge clk);
    check("zero after arvalid", m_axi_arvalid, 1'b0);
    check("zero after ack",     rd_req_ack,    1'b0);

    // Backpressure: size 3 clamps to 2, AR stable for 5 stalled cycles, ack on the 6th.
    m_axi_arready = 1'b0;
    send(32'h0300, 32'd32, 3'd3, 2'b01);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("stall arvalid", m_axi_arvalid, 1'b1);
      check("stall araddr",  m_axi_araddr,  32'h0300);
      check("stall arlen",   m_axi_arlen,   8'd7);
      check("stall arsize",  m_axi_arsize,  3'd2);
      check("stall arburst", m_axi_arburst, 2'b01);
      check("stall ack",     rd_req_ack,    1'b0);
      @(negedge clk);
    end
    m_axi_arready = 1'b1;
    #1;
    check("stall release ack",  rd_req_ack,         1'b1);
    check("stall next_addr",    rd_req_next_addr,   32'h0320);
    check("stall next_len",     rd_req_next_length, 32'd0);
    check("stall done",         rd_req_done,        1'b1);
    @(negedge clk);
    check("stall idle arvalid", m_axi_arvalid, 1'b0);

    // Reset while arvalid is high: request abandoned, no ack even with arready high.
    m_axi_arready = 1'b0;
    send(32'h0500, 32'd16, 3'd2, 2'b01);
    @(negedge clk);
    check("rst pre arvalid", m_axi_arvalid, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    m_axi_arready = 1'b1;
    #1;
    check("rst arvalid", m_axi_arvalid, 1'b0);
    check("rst ack",     rd_req_ack,    1'b0);
    rst = 1'b0;
    burst("post", 32'h0600, 32'd8, 3'd2, 2'b01, 8'd1, 3'd2, 2'b01, 32'h0608, 32'd0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
